// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter that sits on the core data bus beside data
//   memory. Byte writes to TXDATA go into a TX FIFO. An FSM serializes each
//   byte LSB first onto txd: start bit, 8 data bits, optional even parity bit,
//   stop bit.
//
//   Register window (16 bytes at BASE_ADDR, decoded on addr[3:2]):
//     +0x0 TXDATA  : write pushes wdata[7:0]; reads 0
//     +0x4 STATUS  : {16'b0, count[7:0], 3'b0, parity_en, overflow, busy, empty, full}
//                    writing wdata[3]=1 clears overflow
//     +0x8 DIVISOR : [15:0] read/write; bit period = DIVISOR+1 clk cycles
//     +0xC reserved: reads 0, writes ignored
//
//   Build option: define UART_TX_PARITY_EN to add an even-parity bit between
//   data bit 7 and the stop bit. STATUS bit 4 then reads 1.
//
//   Ports:
//     clk, reset   : clock; asynchronous active-high reset
//     addr, wdata  : core data address and store data
//     we           : core MemWrite
//     sel          : combinational window hit, used by the top level to mux rdata
//     rdata        : combinational read data, 0 when sel=0
//     txd          : registered serial output, idles high
//
//   Bus handshake: a write is a one-cycle strobe (we & sel) that completes at
//   the rising edge it is sampled on. There is no ready/backpressure. A push
//   into a full FIFO is dropped and flagged in STATUS.overflow instead of
//   stalling the core.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PARITY_FLAG = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     divisor_q, divisor_d;
    logic [15:0]     timer_q, timer_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic            txd_q, txd_d;

    logic [1:0]      reg_idx;
    logic            wr_txdata, wr_status, wr_divisor;
    logic            full, empty, busy, bit_tick, pop, push_ok;
    logic            unused_bits;

    // Address decode and write strobes.
    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx    = addr[3:2];
    assign wr_txdata  = we & sel & (reg_idx == 2'd0);
    assign wr_status  = we & sel & (reg_idx == 2'd1);
    assign wr_divisor = we & sel & (reg_idx == 2'd2);
    assign unused_bits = ^{addr[1:0], wdata[31:16]};

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign bit_tick = (timer_q == 16'd0);
    assign txd      = txd_q;

    // A push into a full FIFO still fits when the FSM pops the same cycle.
    assign push_ok = wr_txdata & (~full | pop);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_START;
            S_START: if (bit_tick) state_d = S_DATA;
            S_DATA: begin
                if (bit_tick && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_tick) state_d = S_STOP;
`endif
            S_STOP:  if (bit_tick) state_d = empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pop, shift register, bit index, bit timer and txd.
    // The timer reloads from DIVISOR at every bit boundary, so a DIVISOR write
    // mid-frame only changes the bit period from the next boundary on.
    always_comb begin
        pop     = 1'b0;
        shift_d = shift_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        timer_d = bit_tick ? timer_q : timer_q - 16'd1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                    timer_d = divisor_q;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    txd_d   = shift_q[0];
                    idx_d   = 3'd0;
                    timer_d = divisor_q;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    timer_d = divisor_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d = ^shift_q;
`else
                        txd_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shift_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    txd_d   = 1'b1;
                    timer_d = divisor_q;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    timer_d = divisor_q;
                    // Back-to-back frames: the next start bit follows the stop
                    // bit with no idle cycle.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                    end else begin
                        txd_d = 1'b1;
                    end
                end
            end
            default: txd_d = 1'b1;
        endcase
    end

    // FIFO, overflow flag and divisor register.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = wdata[7:0];
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (wr_status && wdata[3]) overflow_d = 1'b0;
        if (wr_txdata && full && !pop) overflow_d = 1'b1;
        divisor_d = wr_divisor ? wdata[15:0] : divisor_q;
    end

    // Combinational read port.
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (reg_idx)
                2'd1:    rdata = {16'd0, 8'(count_q), 3'd0, PARITY_FLAG,
                                  overflow_q, busy, empty, full};
                2'd2:    rdata = {16'd0, divisor_q};
                default: rdata = 32'd0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers; txd is forced high the moment reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            divisor_q  <= DIV_RESET;
            timer_q    <= 16'd0;
            shift_q    <= 8'd0;
            idx_q      <= 3'd0;
            txd_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            divisor_q  <= divisor_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            txd_q      <= txd_d;
        end
    end

    // FIFO storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Self-checking bench for mmio_uart_tx with DIV_RESET=3 and FIFO_DEPTH=8.
//   Register decode and read-back use a table of vectors. Serial frames,
//   FIFO overflow, DIVISOR=0 and reset-abort use hand-written sequences.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, or 1 time unit after an input change for the combinational port.
module tb_mmio_uart_tx;

    localparam logic [31:0] B = 32'h8000_0000;
`ifdef UART_TX_PARITY_EN
    localparam bit          PAR = 1'b1;
    localparam logic [31:0] PB  = 32'h10;
`else
    localparam bit          PAR = 1'b0;
    localparam logic [31:0] PB  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        we = 1'b0;
    logic        sel;
    logic [31:0] rdata;
    logic        txd;

    int checks = 0;
    int failures = 0;

    mmio_uart_tx #(
        .BASE_ADDR (B),
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wdata(wdata),
        .we   (we),
        .sel  (sel),
        .rdata(rdata),
        .txd  (txd)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // One-cycle bus write, entered and left on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        chk(name, rdata, exp);
    endtask

    // Sample one full frame, one falling edge per clock, starting with the
    // start bit on the next falling edge. Optionally check STATUS mid-frame
    // (addr must already point at STATUS).
    task automatic check_frame(input string name, input logic [7:0] data, input int cpb,
                               input bit par, input bit chk_mid, input logic [31:0] mid_exp);
        int   nb;
        int   b;
        int   bad_k;
        bit   bad;
        logic exp_bit;
        logic bad_got;
        logic bad_exp;
        nb  = par ? 11 : 10;
        bad = 1'b0;
        bad_k = 0;
        bad_got = 1'b0;
        bad_exp = 1'b0;
        for (int k = 0; k < nb * cpb; k++) begin
            @(negedge clk);
            b = k / cpb;
            if (b == 0)            exp_bit = 1'b0;
            else if (b <= 8)       exp_bit = data[b-1];
            else if (b == 9 && par) exp_bit = ^data;
            else                   exp_bit = 1'b1;
            if (txd !== exp_bit && !bad) begin
                bad     = 1'b1;
                bad_k   = k;
                bad_got = txd;
                bad_exp = exp_bit;
            end
            if (chk_mid && k == 5 * cpb) chk({name, "_mid_status"}, rdata, mid_exp);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: txd=%0b expected=%0b at cycle %0d of frame 0x%02h",
                     name, bad_got, bad_exp, bad_k, data);
        end
    endtask

    task automatic check_idle_line(input string name, input int cycles);
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: txd=0 seen expected=1 for %0d cycles", name, cycles);
        end
    endtask

    function automatic logic [7:0] burst_byte(input int i);
        return 8'(8'h30 + i * 7);
    endfunction

    initial begin
        // Register decode / read-back table. Write rows show the value that
        // is visible before the write edge.
        vecs[0]  = '{1'b0, B + 32'h4,  32'h0,         1'b1, 32'h2 | PB};
        vecs[1]  = '{1'b0, B + 32'h8,  32'h0,         1'b1, 32'h3};
        vecs[2]  = '{1'b0, B + 32'h0,  32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, B + 32'hC,  32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b1, B + 32'h8,  32'hABCD_1234, 1'b1, 32'h3};
        vecs[5]  = '{1'b0, B + 32'h8,  32'h0,         1'b1, 32'h1234};
        vecs[6]  = '{1'b0, B + 32'hB,  32'h0,         1'b1, 32'h1234};
        vecs[7]  = '{1'b1, B + 32'hC,  32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, B + 32'h8,  32'h0,         1'b1, 32'h1234};
        vecs[9]  = '{1'b1, 32'h64,     32'h55,        1'b0, 32'h0};
        vecs[10] = '{1'b0, B + 32'h4,  32'h0,         1'b1, 32'h2 | PB};
        vecs[11] = '{1'b1, B + 32'h10, 32'h99,        1'b0, 32'h0};
        vecs[12] = '{1'b0, B + 32'h4,  32'h0,         1'b1, 32'h2 | PB};
        vecs[13] = '{1'b1, B + 32'h8,  32'h3,         1'b1, 32'h1234};
        vecs[14] = '{1'b0, B + 32'h8,  32'h0,         1'b1, 32'h3};

        // Reset
        repeat (3) @(negedge clk);
        chk("reset_txd", {31'd0, txd}, 32'h1);
        reset = 1'b0;

        // Table-driven register vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            we    = vecs[i].we;
            #1;
            chk($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        @(negedge clk);
        we = 1'b0;
        chk("idle_txd_after_vectors", {31'd0, txd}, 32'h1);

        // Single byte 0x55 at DIVISOR=3: 1-cycle latency, 40-cycle frame
        bus_write(B, 32'h55);
        chk("latency_txd_still_high", {31'd0, txd}, 32'h1);
        addr = B + 32'h4;
        check_frame("frame_55", 8'h55, 4, PAR, 1'b1, 32'h6 | PB);
        @(negedge clk);
        chk("after_55_txd", {31'd0, txd}, 32'h1);
        read_chk("after_55_status", B + 32'h4, 32'h2 | PB);

        // Ten back-to-back writes: nine accepted, one dropped, nine frames
        // with no idle gap.
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 10; i++) bus_write(B, {24'd0, burst_byte(i)});
                read_chk("burst_status_full_ovf", B + 32'h4, 32'h80D | PB);
                bus_write(B + 32'h4, 32'h8);
                read_chk("burst_status_ovf_clear", B + 32'h4, 32'h805 | PB);
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 9; i++)
                    check_frame($sformatf("burst_frame%0d", i), burst_byte(i), 4, PAR, 1'b0, 32'h0);
            end
        join
        @(negedge clk);
        chk("burst_end_txd", {31'd0, txd}, 32'h1);
        read_chk("burst_end_status", B + 32'h4, 32'h2 | PB);

        // DIVISOR=0: one cycle per bit, 0xA5
        @(negedge clk);
        bus_write(B + 32'h8, 32'h0);
        bus_write(B, 32'hA5);
        check_frame("frame_a5_div0", 8'hA5, 1, PAR, 1'b0, 32'h0);
        @(negedge clk);
        read_chk("after_a5_status", B + 32'h4, 32'h2 | PB);

        // Reset during DATA bit 3 (DIVISOR still 0): txd high at once, no resume
        @(negedge clk);
        bus_write(B, 32'h00);
        repeat (5) @(negedge clk);
        chk("pre_reset_bit3_txd", {31'd0, txd}, 32'h0);
        #1 reset = 1'b1;
        #1 chk("reset_forces_txd", {31'd0, txd}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        read_chk("post_reset_status", B + 32'h4, 32'h2 | PB);
        read_chk("post_reset_divisor", B + 32'h8, 32'h3);
        check_idle_line("post_reset_no_frame", 50);

`ifdef UART_TX_PARITY_EN
        // Even parity of 0x07 is 1; 44-cycle frame
        bus_write(B, 32'h07);
        addr = B + 32'h4;
        check_frame("frame_07_parity", 8'h07, 4, 1'b1, 1'b1, 32'h16);
        @(negedge clk);
        read_chk("after_parity_status", B + 32'h4, 32'h12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
